dkong_pal_load_ctrl: RTL

//  Sequences loading of the two 256x8 colour palette RAMs (col2 = B/low half, col1 = R/G half) from a

---
 rtl/dkong_pal_load_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dkong_pal_load_ctrl.sv
// Palette RAM load sequencer: streams 512 bytes into col2 then col1 palette RAMs,
// with optional blank-only gating and an additive checksum check at the end.
module dkong_pal_load_ctrl #(
  parameter bit          BLANK_ONLY = 1'b0,
  parameter bit          CHECK_EN   = 1'b0,
  parameter logic [15:0] EXP_SUM    = 16'h0
) (
  input  logic        CLK_24M,
  input  logic        W_1EF_RST,
  input  logic        I_START,
  input  logic        I_ABORT,
  input  logic        I_DL_VALID,
  input  logic [7:0]  I_DL_DATA,
  output logic        O_DL_READY,
  input  logic        I_CMPBLKn,
  output logic [7:0]  O_WR_ADDR,
  output logic [7:0]  O_WR_DATA,
  output logic        O_WR_COL2,
  output logic        O_WR_COL1,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_ERR,
  output logic [15:0] O_SUM
);

  typedef enum logic [1:0] {IDLE, LOAD2, LOAD1, CHECK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_col2_q, wr_col2_d;
  logic        wr_col1_q, wr_col1_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic loading, blank_ok, ready, accept;

  assign loading  = (state_q == LOAD2) || (state_q == LOAD1);
  assign blank_ok = (BLANK_ONLY == 1'b0) || !I_CMPBLKn;
  assign ready    = loading && blank_ok && !I_ABORT;
  assign accept   = I_DL_VALID && ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_col2_d = 1'b0;
    wr_col1_d = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;

    // Write port lags the accept by one cycle; address/data hold between strobes.
    if (accept) begin
      wr_addr_d = addr_q;
      wr_data_d = I_DL_DATA;
      wr_col2_d = (state_q == LOAD2);
      wr_col1_d = (state_q == LOAD1);
      addr_d    = addr_q + 8'd1;
      sum_d     = sum_q + {8'h00, I_DL_DATA};
    end

    case (state_q)
      IDLE: begin
        if (I_START) begin
          state_d = LOAD2;
          addr_d  = 8'd0;
          sum_d   = 16'd0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      LOAD2, LOAD1: begin
        if (I_ABORT) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b1;
        end else if (accept && (addr_q == 8'hFF)) begin
          state_d = (state_q == LOAD2) ? LOAD1 : CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = CHECK_EN && (sum_q != EXP_SUM);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      state_q   <= IDLE;
      addr_q    <= 8'd0;
      sum_q     <= 16'd0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      wr_col2_q <= 1'b0;
      wr_col1_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_col2_q <= wr_col2_d;
      wr_col1_q <= wr_col1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign O_DL_READY = ready;
  assign O_WR_ADDR  = wr_addr_q;
  assign O_WR_DATA  = wr_data_q;
  assign O_WR_COL2  = wr_col2_q;
  assign O_WR_COL1  = wr_col1_q;
  assign O_BUSY     = busy_q;
  assign O_DONE     = done_q;
  assign O_ERR      = err_q;
  assign O_SUM      = sum_q;

endmodule
